// File: rtl/banner_sequencer_if.sv
// -----------------------------------------------------------------------------
// banner_sequencer_if
// Groups the game-event pulses and the banner/gameplay control outputs of the
// banner sequencer into one bundle.
//   master : game-logic side; drives the event pulses and observes the enables
//   slave  : banner_sequencer; consumes the pulses and drives the enables
// Signals:
//   frame_tick  - one-cycle pulse per VGA frame
//   win/lose    - one-cycle round-result pulses
//   restart     - one-cycle pulse requesting a new round
//   play_en     - gameplay active
//   congrats_en - CONGRATS banner renderer enable
//   gameover_en - GAME OVER banner renderer enable
//   hold        - banner steady, waiting for restart
// -----------------------------------------------------------------------------
interface banner_sequencer_if;
  logic frame_tick;
  logic win;
  logic lose;
  logic restart;
  logic play_en;
  logic congrats_en;
  logic gameover_en;
  logic hold;

  modport master (
    output frame_tick, win, lose, restart,
    input  play_en, congrats_en, gameover_en, hold
  );

  modport slave (
    input  frame_tick, win, lose, restart,
    output play_en, congrats_en, gameover_en, hold
  );
endinterface

// File: rtl/banner_sequencer.sv
// -----------------------------------------------------------------------------
// banner_sequencer
// Sequences the end-of-round banners: on win/lose the matching banner blinks
// with a half-period of BLINK_FRAMES frames for SHOW_FRAMES frames in total,
// then holds steady until the player restarts.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - banner_sequencer_if.slave (event pulses in, enables out)
// Parameters:
//   BLINK_FRAMES - frames per blink half-period (1..2^CNT_W)
//   SHOW_FRAMES  - frames spent blinking before hold (1..2^CNT_W)
//   CNT_W        - frame counter width
// -----------------------------------------------------------------------------
module banner_sequencer #(
  parameter int BLINK_FRAMES = 15,
  parameter int SHOW_FRAMES  = 180,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  banner_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_BLINK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Terminal counter values; the legal parameter range keeps both in CNT_W bits.
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  state_t           r_state;
  logic             r_msg_sel;     // 0 = win banner, 1 = lose banner
  logic             r_vis;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_blink_cnt;

  logic             r_play_en;
  logic             r_congrats_en;
  logic             r_gameover_en;
  logic             r_hold;

  logic             w_last_frame;
  logic             w_last_blink;

  assign w_last_frame = (r_frame_cnt == SHOW_LAST);
  assign w_last_blink = (r_blink_cnt == BLINK_LAST);

  // Outputs are registered alongside the state: every branch that changes
  // state/vis/msg_sel also writes the enables from those new values, so the
  // enables always match the state one cycle after the triggering event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_PLAY;
      r_msg_sel     <= 1'b0;
      r_vis         <= 1'b0;
      r_frame_cnt   <= '0;
      r_blink_cnt   <= '0;
      r_play_en     <= 1'b1;
      r_congrats_en <= 1'b0;
      r_gameover_en <= 1'b0;
      r_hold        <= 1'b0;
    end else begin
      case (r_state)
        S_PLAY: begin
          // restart and frame_tick have no effect here; win beats lose.
          if (bus.win || bus.lose) begin
            r_state       <= S_BLINK;
            r_frame_cnt   <= '0;
            r_blink_cnt   <= '0;
            r_vis         <= 1'b1;
            r_msg_sel     <= bus.lose & ~bus.win;
            r_play_en     <= 1'b0;
            r_congrats_en <= bus.win;
            r_gameover_en <= bus.lose & ~bus.win;
            r_hold        <= 1'b0;
          end
        end

        S_BLINK, S_HOLD: begin
          if (bus.restart) begin
            r_state       <= S_PLAY;
            r_frame_cnt   <= '0;
            r_blink_cnt   <= '0;
            r_vis         <= 1'b0;
            r_play_en     <= 1'b1;
            r_congrats_en <= 1'b0;
            r_gameover_en <= 1'b0;
            r_hold        <= 1'b0;
          end else if ((r_state == S_BLINK) && bus.frame_tick) begin
            if (w_last_frame) begin
              // Banner becomes steady regardless of the current blink phase.
              r_state       <= S_HOLD;
              r_vis         <= 1'b1;
              r_hold        <= 1'b1;
              r_congrats_en <= ~r_msg_sel;
              r_gameover_en <= r_msg_sel;
            end else begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
              if (w_last_blink) begin
                r_blink_cnt   <= '0;
                r_vis         <= ~r_vis;
                r_congrats_en <= ~r_vis & ~r_msg_sel;
                r_gameover_en <= ~r_vis & r_msg_sel;
              end else begin
                r_blink_cnt <= r_blink_cnt + CNT_W'(1);
              end
            end
          end
          // HOLD without restart: everything frozen.
        end

        default: begin
          // Unreachable encoding: fall back to the reset condition.
          r_state       <= S_PLAY;
          r_msg_sel     <= 1'b0;
          r_vis         <= 1'b0;
          r_frame_cnt   <= '0;
          r_blink_cnt   <= '0;
          r_play_en     <= 1'b1;
          r_congrats_en <= 1'b0;
          r_gameover_en <= 1'b0;
          r_hold        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.play_en     = r_play_en;
  assign bus.congrats_en = r_congrats_en;
  assign bus.gameover_en = r_gameover_en;
  assign bus.hold        = r_hold;

endmodule

// File: tb/tb_banner_sequencer.sv
module tb_banner_sequencer;
  localparam int BLINK = 2;
  localparam int SHOW  = 6;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  banner_sequencer_if bus ();

  banner_sequencer #(
    .BLINK_FRAMES(BLINK),
    .SHOW_FRAMES (SHOW),
    .CNT_W       (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: banner shown or not, which message, and how many frame
  // ticks have been counted since the banner appeared.
  bit m_banner;
  bit m_msg;
  int m_k;

  task automatic model_reset();
    m_banner = 0; m_msg = 0; m_k = 0;
  endtask

  task automatic model_step(input bit t, input bit w, input bit l, input bit r);
    if (m_banner) begin
      if (r) begin
        m_banner = 0; m_k = 0;
      end else if (t && m_k < SHOW) begin
        m_k++;
      end
    end else if (w || l) begin
      m_banner = 1; m_msg = l && !w; m_k = 0;
    end
  endtask

  // {play_en, congrats_en, gameover_en, hold}
  function automatic logic [3:0] exp_outs();
    bit v;
    v = (m_k >= SHOW) ? 1'b1 : (((m_k / BLINK) % 2) == 0);
    return {!m_banner, m_banner && v && !m_msg, m_banner && v && m_msg,
            m_banner && (m_k >= SHOW)};
  endfunction

  function automatic logic [3:0] obs();
    return {bus.play_en, bus.congrats_en, bus.gameover_en, bus.hold};
  endfunction

  // One clock with the given pulses; outputs are stable 1 time unit after.
  task automatic cycle(input bit t, input bit w, input bit l, input bit r);
    bus.frame_tick = t; bus.win = w; bus.lose = l; bus.restart = r;
    @(posedge clk);
    #1;
    bus.frame_tick = 0; bus.win = 0; bus.lose = 0; bus.restart = 0;
    model_step(t, w, l, r);
  endtask

  task automatic test_reset();
    rst = 0;
    #3 rst = 1;
    #1;
    checks++;
    if (obs() !== 4'b1000) begin
      $display("FAIL reset_async: got %b want %b", obs(), 4'b1000); errors++;
    end
    @(negedge clk) rst = 0;
    model_reset();
    cycle(1, 0, 0, 0);
    checks++;
    if (obs() !== exp_outs()) begin
      $display("FAIL reset_idle: got %b want %b", obs(), exp_outs()); errors++;
    end
  endtask

  task automatic test_win_blink();
    logic [6:0] want_c;
    want_c = 7'b1100111;  // entry, then ticks 1..6
    cycle(0, 1, 0, 0);
    checks++;
    if (bus.congrats_en !== want_c[6] || bus.gameover_en !== 1'b0) begin
      $display("FAIL win_entry: got c=%b g=%b want c=1 g=0", bus.congrats_en, bus.gameover_en); errors++;
    end
    for (int i = 1; i <= 7; i++) begin
      cycle(1, 0, 0, 0);
      checks++;
      if (bus.congrats_en !== ((i <= 6) ? want_c[6-i] : 1'b1) || bus.gameover_en !== 1'b0 ||
          bus.hold !== (i >= 6) || obs() !== exp_outs()) begin
        $display("FAIL win_blink tick %0d: got %b want %b", i, obs(), exp_outs()); errors++;
      end
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (obs() !== 4'b1000) begin
      $display("FAIL win_restart: got %b want 1000", obs()); errors++;
    end
  endtask

  task automatic test_simultaneous();
    cycle(1, 1, 1, 0);
    checks++;
    if (obs() !== 4'b0100 || dut.r_frame_cnt !== 8'd0) begin
      $display("FAIL simul_events: got %b cnt=%0d want 0100 cnt=0", obs(), dut.r_frame_cnt); errors++;
    end
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);  // lose during BLINK is ignored
    checks++;
    if (obs() !== exp_outs() || obs() !== 4'b0100) begin
      $display("FAIL simul_lose_ignored: got %b want %b", obs(), exp_outs()); errors++;
    end
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    checks++;
    if (obs() !== 4'b0101 || obs() !== exp_outs()) begin
      $display("FAIL simul_hold: got %b want 0101", obs()); errors++;
    end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_restart_mid_blink();
    cycle(0, 0, 1, 0);
    checks++;
    if (obs() !== 4'b0010) begin
      $display("FAIL lose_entry: got %b want 0010", obs()); errors++;
    end
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    checks++;
    if (obs() !== 4'b1000) begin
      $display("FAIL restart_mid_blink: got %b want 1000", obs()); errors++;
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (obs() !== 4'b0010) begin
      $display("FAIL relose_entry: got %b want 0010", obs()); errors++;
    end
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 0, 0, 0);
      checks++;
      if (obs() !== exp_outs()) begin
        $display("FAIL relose_blink tick %0d: got %b want %b", i, obs(), exp_outs()); errors++;
      end
    end
  endtask

  task automatic test_restart_hold_and_play();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);  // finishes the lose pattern
    checks++;
    if (obs() !== 4'b0011) begin
      $display("FAIL lose_hold: got %b want 0011", obs()); errors++;
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (obs() !== 4'b1000) begin
      $display("FAIL restart_from_hold: got %b want 1000", obs()); errors++;
    end
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    checks++;
    if (obs() !== 4'b1000 || obs() !== exp_outs()) begin
      $display("FAIL restart_in_play: got %b want 1000", obs()); errors++;
    end
  endtask

  task automatic test_reset_mid_hold();
    cycle(0, 0, 1, 0);
    for (int i = 0; i < SHOW; i++) cycle(1, 0, 0, 0);
    checks++;
    if (obs() !== 4'b0011) begin
      $display("FAIL pre_reset_hold: got %b want 0011", obs()); errors++;
    end
    #2 rst = 1;
    #1;
    checks++;
    if (obs() !== 4'b1000) begin
      $display("FAIL reset_mid_hold: got %b want 1000", obs()); errors++;
    end
    @(negedge clk) rst = 0;
    model_reset();
    cycle(0, 1, 0, 0);
    checks++;
    if (obs() !== 4'b0100) begin
      $display("FAIL win_after_reset: got %b want 0100", obs()); errors++;
    end
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    checks++;
    if (obs() !== 4'b0000 || obs() !== exp_outs()) begin
      $display("FAIL win_after_reset_blink: got %b want 0000", obs()); errors++;
    end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit t, w, l, r;
    for (int i = 0; i < 400; i++) begin
      t = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 99) < 4);
      l = ($urandom_range(0, 99) < 4);
      r = ($urandom_range(0, 99) < 3);
      cycle(t, w, l, r);
      checks++;
      if (obs() !== exp_outs()) begin
        $display("FAIL random cyc %0d (t%0d w%0d l%0d r%0d): got %b want %b",
                 i, t, w, l, r, obs(), exp_outs());
        errors++;
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    bus.frame_tick = 0; bus.win = 0; bus.lose = 0; bus.restart = 0;
    model_reset();
    test_reset();
    test_win_blink();
    test_simultaneous();
    test_restart_mid_blink();
    test_restart_hold_and_play();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
